// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial WIDTH-bit ALU built around one 1-bit ALU slice, LSB first.
// Define ALU_SERIAL_ZERO_EN to build the registered zero flag; otherwise zero_o is tied 0.
module ALU (
   input  logic       a_i,
   input  logic       b_i,
   input  logic       c_i,
   input  logic       invert_i,
   input  logic       less_i,
   input  logic       sltu_i,
   input  logic [3:0] operacion_i,
   output logic       salida_o,
   output logic       c_o,
   output logic       set_o
);
   logic b_x, sum;
   always_comb begin
      b_x      = b_i ^ invert_i;
      sum      = a_i ^ b_x ^ c_i;
      c_o      = (a_i & b_x) | (c_i & (a_i ^ b_x));
      set_o    = sum;
      salida_o = (operacion_i == 4'b0000) ? a_i & b_i :
                 (operacion_i == 4'b0001) ? a_i | b_i :
                 (operacion_i == 4'b0010) ? sum :
                 (operacion_i == 4'b0011) ? sum :
                 (operacion_i == 4'b0100) ? a_i ^ b_i :
                 (operacion_i == 4'b0101) ? less_i :
                 (operacion_i == 4'b0110) ? sltu_i : 1'b0;
   end
endmodule

module alu_serial_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [3:0]       operacion_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic             carry_o,
   output logic             zero_o
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
   logic [3:0]       op_q, op_d;
   logic             carry_q, carry_d, set_msb_q, set_msb_d, cin_msb_q, cin_msb_d, cout_msb_q, cout_msb_d;
   logic             accept, last, is_slt, is_arith, sal, slice_c, slice_set, lt;

   function automatic logic inv_op(input logic [3:0] op);
      return (op == 4'b0011) | (op == 4'b0101) | (op == 4'b0110);
   endfunction

   ALU u_slice (
      .a_i        (a_q[0]),
      .b_i        (b_q[0]),
      .c_i        (carry_q),
      .invert_i   (inv_op(op_q)),
      .less_i     (1'b0),
      .sltu_i     (1'b0),
      .operacion_i(op_q),
      .salida_o   (sal),
      .c_o        (slice_c),
      .set_o      (slice_set)
   );

   assign accept   = (state_q == IDLE) & start_i;
   assign last     = cnt_q == CW'(WIDTH - 1);
   assign is_slt   = (op_q == 4'b0101) | (op_q == 4'b0110);
   assign is_arith = is_slt | (op_q == 4'b0010) | (op_q == 4'b0011);
   // signed compare corrects the sign bit by the overflow seen at the MSB
   assign lt       = (op_q == 4'b0101) ? set_msb_q ^ cin_msb_q ^ cout_msb_q : ~cout_msb_q;

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;

   always_comb begin
      state_d = (state_q == IDLE) ? (start_i ? RUN : IDLE) :
                (state_q == RUN)  ? (last ? (is_slt ? FIX : DONE) : RUN) :
                (state_q == FIX)  ? DONE : IDLE;
   end

   always_comb begin
      busy_o   = (state_q == RUN) | (state_q == FIX);
      done_o   = state_q == DONE;
      result_o = result_q;
      carry_o  = is_arith & cout_msb_q;
   end

   always_comb begin
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      cnt_d      = cnt_q;
      result_d   = result_q;
      carry_d    = carry_q;
      set_msb_d  = set_msb_q;
      cin_msb_d  = cin_msb_q;
      cout_msb_d = cout_msb_q;
      if (accept) begin
         a_d      = a_i;
         b_d      = b_i;
         op_d     = operacion_i;
         cnt_d    = '0;
         result_d = '0;
         carry_d  = inv_op(operacion_i);
      end else if (state_q == RUN) begin
         result_d   = {sal, result_q[WIDTH-1:1]};
         a_d        = a_q >> 1;
         b_d        = b_q >> 1;
         carry_d    = slice_c;
         cnt_d      = cnt_q + CW'(1);
         set_msb_d  = last ? slice_set : set_msb_q;
         cin_msb_d  = last ? carry_q : cin_msb_q;
         cout_msb_d = last ? slice_c : cout_msb_q;
      end else if (state_q == FIX) begin
         result_d = {{(WIDTH-1){1'b0}}, lt};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         cnt_q      <= '0;
         result_q   <= '0;
         carry_q    <= 1'b0;
         set_msb_q  <= 1'b0;
         cin_msb_q  <= 1'b0;
         cout_msb_q <= 1'b0;
      end else begin
         a_q        <= a_d;
         b_q        <= b_d;
         op_q       <= op_d;
         cnt_q      <= cnt_d;
         result_q   <= result_d;
         carry_q    <= carry_d;
         set_msb_q  <= set_msb_d;
         cin_msb_q  <= cin_msb_d;
         cout_msb_q <= cout_msb_d;
      end

`ifdef ALU_SERIAL_ZERO_EN
   logic flag_q, flag_d, zero_q, zero_d;
   // zero_q is published only on entry to DONE so it reads 0 through reset and RUN
   always_comb begin
      flag_d = flag_q;
      zero_d = zero_q;
      if (accept) begin
         flag_d = 1'b0;
         zero_d = 1'b0;
      end else if (state_q == RUN) begin
         flag_d = flag_q | sal;
         zero_d = (last & ~is_slt) ? ~(flag_q | sal) : zero_q;
      end else if (state_q == FIX) begin
         flag_d = lt;
         zero_d = ~lt;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         flag_q <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         flag_q <= flag_d;
         zero_q <= zero_d;
      end

   assign zero_o = zero_q;
`else
   assign zero_o = 1'b0;
`endif
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// tb_alu_serial_ctrl: directed vectors with a queue scoreboard checked on every done_o pulse.
module tb_alu_serial_ctrl;
   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        start_i = 1'b0;
   logic [3:0]  operacion_i = '0;
   logic [31:0] a_i = '0, b_i = '0;
   logic        busy_o, done_o, carry_o, zero_o;
   logic [31:0] result_o;

   typedef struct {
      logic [31:0] r;
      logic        c;
      logic        z;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0, n_errors = 0;
   int   k = 0;
   logic prev_busy = 1'b0, prev_done = 1'b0;

   alu_serial_ctrl #(.WIDTH(32)) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .start_i    (start_i),
      .operacion_i(operacion_i),
      .a_i        (a_i),
      .b_i        (b_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .result_o   (result_o),
      .carry_o    (carry_o),
      .zero_o     (zero_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s timed out", name);
   endtask

   function automatic logic zexp(input logic [31:0] r);
`ifdef ALU_SERIAL_ZERO_EN
      return r == 32'd0;
`else
      return 1'b0;
`endif
   endfunction

   // latency counts the accept edge as cycle 1
   always @(negedge clk_i) begin
      if (!rst_ni) begin
         prev_busy = 1'b0;
         prev_done = 1'b0;
      end else begin
         if (busy_o && !prev_busy) k = 0;
         else if (busy_o || done_o) k++;
         if (done_o) begin
            if (sb.size() == 0) timeout("scoreboard_empty");
            else begin
               exp_t e;
               e = sb.pop_front();
               chk("result", result_o, e.r);
               chk("carry", 32'(carry_o), 32'(e.c));
               chk("zero", 32'(zero_o), 32'(e.z));
               chk("latency", k + 1, e.lat);
               chk("busy_at_done", 32'(busy_o), 32'd0);
               chk("done_single", 32'(prev_done), 32'd0);
            end
         end
         prev_busy = busy_o;
         prev_done = done_o;
      end
   end

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic c, input int lat, input bit hold);
      int t = 0;
      while ((busy_o || done_o) && t < 300) begin
         @(negedge clk_i);
         t++;
      end
      if (t >= 300) timeout("idle_wait");
      operacion_i = op;
      a_i         = a;
      b_i         = b;
      start_i     = 1'b1;
      sb.push_back('{r: r, c: c, z: zexp(r), lat: lat});
      @(negedge clk_i);
      if (hold) begin
         operacion_i = 4'b0011;
         a_i         = $urandom;
         b_i         = $urandom;
         t = 0;
         while (!done_o && t < 300) begin
            @(negedge clk_i);
            t++;
         end
         if (t >= 300) timeout("hold_done_wait");
      end
      start_i = 1'b0;
   endtask

   initial begin
      #12;
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_result", result_o, 32'd0);
      chk("rst_carry", 32'(carry_o), 32'd0);
      chk("rst_zero", 32'(zero_o), 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      issue(4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 33, 0);
      issue(4'b0011, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 33, 0);
      issue(4'b0011, 32'd9, 32'd9, 32'h00000000, 1'b1, 33, 0);
      issue(4'b0101, 32'h80000000, 32'h00000001, 32'h00000001, 1'b1, 34, 0);
      issue(4'b0110, 32'h80000000, 32'h00000001, 32'h00000000, 1'b1, 34, 0);
      issue(4'b0101, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 34, 0);
      issue(4'b0110, 32'h00000001, 32'h80000000, 32'h00000001, 1'b0, 34, 0);
      issue(4'b0000, 32'hF0F01234, 32'h0FF0FFFF, 32'h00F01234, 1'b0, 33, 0);
      issue(4'b0001, 32'hF0F01234, 32'h0FF0FFFF, 32'hFFF0FFFF, 1'b0, 33, 0);
      issue(4'b0100, 32'hF0F01234, 32'h0FF0FFFF, 32'hFF00EDCB, 1'b0, 33, 0);
      issue(4'b0111, 32'hF0F01234, 32'h0FF0FFFF, 32'h00000000, 1'b0, 33, 0);
      issue(4'b0010, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 33, 1);
      issue(4'b0010, 32'h00000010, 32'h00000020, 32'h00000030, 1'b0, 33, 0);
      // abort an ADD mid-RUN
      issue(4'b0010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 33, 0);
      repeat (9) @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      sb.delete();
      chk("mid_rst_busy", 32'(busy_o), 32'd0);
      chk("mid_rst_done", 32'(done_o), 32'd0);
      chk("mid_rst_result", result_o, 32'd0);
      chk("mid_rst_carry", 32'(carry_o), 32'd0);
      chk("mid_rst_zero", 32'(zero_o), 32'd0);
      repeat (3) @(negedge clk_i);
      chk("mid_rst_no_done", 32'(done_o), 32'd0);
      rst_ni = 1'b1;
      issue(4'b0010, 32'd3, 32'd4, 32'd7, 1'b0, 33, 0);
      begin
         int t = 0;
         while (sb.size() != 0 && t < 300) begin
            @(negedge clk_i);
            t++;
         end
         if (t >= 300) timeout("drain");
      end
      @(negedge clk_i);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
